// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART definitions: FSM encoding, bit-period and counter-width helpers
package uart_pkg;

   localparam int DATA_BITS = 8;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_START     = 3'd1,
      ST_DATA      = 3'd2,
      ST_STOP      = 3'd3,
      ST_WAIT_HIGH = 3'd4
   } uart_state_e;

   function automatic int clk_per_bit(input int clk_freq, input int baud);
      return clk_freq / baud;
   endfunction

   // A one-cycle bit period would give $clog2 == 0; keep the counter at least one bit wide.
   function automatic int cnt_width(input int cpb);
      return (cpb > 1) ? $clog2(cpb) : 1;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for a single asynchronous input
module sync_2ff #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         meta_q <= RESET_VAL;
         sync_q <= RESET_VAL;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 LSB-first UART receiver with mid-bit sampling and framing-error detection
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLK_FREQ = 100_000_000,
   parameter int BAUD     = 10_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] data_out,
   output logic       valid,
   output logic       frame_err,
   output logic       busy
);

   localparam int CLK_PER_BIT = clk_per_bit(CLK_FREQ, BAUD);
   localparam int CNT_W       = cnt_width(CLK_PER_BIT);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLK_PER_BIT / 2 - 1);

   generate
      if (CLK_PER_BIT < 4) begin : g_bad_cfg
         $error("uart_rx: CLK_FREQ/BAUD must be at least 4");
      end
   endgenerate

   logic rx_s;

   sync_2ff #(
      .RESET_VAL(1'b1)
   ) u_sync (
      .clk_i(clk),
      .rst_i(rst),
      .d_i  (rx),
      .q_o  (rx_s)
   );

   uart_state_e          state_q;
   logic [CNT_W-1:0]     cnt_q;
   logic [2:0]           bit_cnt_q;
   logic [DATA_BITS-1:0] shift_q;
   logic [DATA_BITS-1:0] data_q;
   logic                 valid_q;
   logic                 ferr_q;
   logic                 busy_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         ferr_q    <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;

         case (state_q)
            ST_IDLE: begin
               cnt_q <= '0;
               if (!rx_s) begin
                  state_q <= ST_START;
                  busy_q  <= 1'b1;
               end
            end

            // Re-check the start bit at its middle so a short low glitch is ignored.
            ST_START: begin
               if (cnt_q == CNT_HALF) begin
                  cnt_q <= '0;
                  if (!rx_s) begin
                     state_q   <= ST_DATA;
                     bit_cnt_q <= '0;
                  end else begin
                     state_q <= ST_IDLE;
                     busy_q  <= 1'b0;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end

            ST_DATA: begin
               if (cnt_q == CNT_LAST) begin
                  cnt_q     <= '0;
                  shift_q   <= {rx_s, shift_q[DATA_BITS-1:1]};
                  bit_cnt_q <= bit_cnt_q + 1'b1;
                  if (bit_cnt_q == 3'd7) begin
                     state_q <= ST_STOP;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end

            // Leaving at mid-stop leaves half a bit to spot an immediately following start edge.
            ST_STOP: begin
               if (cnt_q == CNT_LAST) begin
                  cnt_q <= '0;
                  if (rx_s) begin
                     data_q  <= shift_q;
                     valid_q <= 1'b1;
                     state_q <= ST_IDLE;
                     busy_q  <= 1'b0;
                  end else begin
                     ferr_q  <= 1'b1;
                     state_q <= ST_WAIT_HIGH;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end

            ST_WAIT_HIGH: begin
               cnt_q <= '0;
               if (rx_s) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end
            end

            default: begin
               state_q <= ST_IDLE;
               cnt_q   <= '0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign data_out  = data_q;
   assign valid     = valid_q;
   assign frame_err = ferr_q;
   assign busy      = busy_q;

endmodule
